// File: rtl/reg_file16_pkg.sv
// -----------------------------------------------------------------------------
// Package arm_regs_pkg
// Purpose : Shared types and constants for the 16-entry ARMv4 register bank
//           (reg_file16) and its read-port selectors.
// Contents: reg_addr_t, PC_IDX, NUM_REGS, STORED_REGS, BYPASS_EN, is_pc().
// Build   : REGFILE_BYPASS_EN selects write-first reads on a same-edge
//           read/write of one address. Leave it undefined for read-first.
// -----------------------------------------------------------------------------
package arm_regs_pkg;

  typedef logic [3:0] reg_addr_t;

  localparam reg_addr_t PC_IDX      = 4'd15;
  localparam int        NUM_REGS    = 16;
  // R15 is not stored, so only R0-R14 are backed by flops.
  localparam int        STORED_REGS = NUM_REGS - 1;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  // True when an address names the program counter (R15).
  function automatic logic is_pc(input reg_addr_t addr);
    return (addr == PC_IDX);
  endfunction

endpackage

// File: rtl/reg_file16_if.sv
// -----------------------------------------------------------------------------
// Interface reg_file16_if
// Purpose : Groups the read-request, write-back and response signals of the
//           register bank.
// Signals : ren, ra1/ra2/ra3, pc8  - read request (master -> slave)
//           we, wa, wd             - write-back   (master -> slave)
//           rd1/rd2/rd3, rvalid    - read data    (slave -> master)
//           pc_wr                  - rejected R15 write pulse (slave -> master)
// Modports: master (datapath or testbench), slave (reg_file16).
// -----------------------------------------------------------------------------
interface reg_file16_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 4
);

  logic              ren;
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [ADDR_W-1:0] ra3;
  logic [WIDTH-1:0]  pc8;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [WIDTH-1:0]  wd;
  logic [WIDTH-1:0]  rd1;
  logic [WIDTH-1:0]  rd2;
  logic [WIDTH-1:0]  rd3;
  logic              rvalid;
  logic              pc_wr;

  modport master (
    output ren, ra1, ra2, ra3, pc8, we, wa, wd,
    input  rd1, rd2, rd3, rvalid, pc_wr
  );

  modport slave (
    input  ren, ra1, ra2, ra3, pc8, we, wa, wd,
    output rd1, rd2, rd3, rvalid, pc_wr
  );

endinterface

// File: rtl/reg_file16_read_port.sv
// -----------------------------------------------------------------------------
// Module reg_read_port
// Purpose : Combinational 16:1 operand selector for one read port of the
//           register bank. R15 always returns pc8. With REGFILE_BYPASS_EN
//           defined, a same-edge write to the addressed register (other than
//           R15) is forwarded (write-first). Otherwise the stored value is
//           returned (read-first).
// Ports   : regs_i  - stored R0-R14
//           ra_i    - read address
//           pc8_i   - PC+8, returned for R15
//           we_i, wa_i, wd_i - write-back port, used for the bypass compare
//           rdata_o - selected operand (unregistered)
// -----------------------------------------------------------------------------
module reg_read_port
  import arm_regs_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] regs_i [0:STORED_REGS-1],
  input  reg_addr_t        ra_i,
  input  logic [WIDTH-1:0] pc8_i,
  input  logic             we_i,
  input  reg_addr_t        wa_i,
  input  logic [WIDTH-1:0] wd_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic bypass_hit_s;

  // A write to R15 is never forwarded because R15 is not storage.
  assign bypass_hit_s = BYPASS_EN && we_i && (ra_i == wa_i) && !is_pc(wa_i);

  // Operand select: the R15 override first, then the bypass, then storage.
  always_comb begin
    rdata_o = '0;
    if (is_pc(ra_i)) begin
      rdata_o = pc8_i;
    end else if (bypass_hit_s) begin
      rdata_o = wd_i;
    end else begin
      rdata_o = regs_i[ra_i];
    end
  end

endmodule

// File: rtl/reg_file16.sv
// -----------------------------------------------------------------------------
// Module reg_file16
// Purpose : 16-entry ARMv4 register bank (R0-R15) with three registered read
//           ports (Rn, Rm, Rs) and one write-back port. R15 is not stored.
//           Reads of R15 return pc8, and writes to R15 are dropped and
//           reported on pc_wr for one cycle.
// Ports   : clk   - rising-edge clock
//           reset - asynchronous, active-high reset
//           bus   - reg_file16_if.slave (ren/ra1-3/pc8, we/wa/wd,
//                   rd1-3/rvalid, pc_wr)
// Timing  : read data is available one cycle after ren. rd1-rd3 hold
//           their last values while ren is low.
// Build   : REGFILE_BYPASS_EN defined  -> write-first on same-edge hazard
//           REGFILE_BYPASS_EN undefined -> read-first (forwarding unit covers it)
// -----------------------------------------------------------------------------
module reg_file16
  import arm_regs_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 4
) (
  input  logic          clk,
  input  logic          reset,
  reg_file16_if.slave   bus
);

  // Stored registers R0-R14.
  logic [WIDTH-1:0]  regs_q [0:STORED_REGS-1];

  // Registered read outputs and status pulses.
  logic [WIDTH-1:0]  rd1_q, rd2_q, rd3_q;
  logic [WIDTH-1:0]  rd1_d, rd2_d, rd3_d;
  logic              rvalid_q, rvalid_d;
  logic              pc_wr_q, pc_wr_d;

  // Combinational operands from the three selectors.
  logic [WIDTH-1:0]  sel1_s, sel2_s, sel3_s;

  // Local copies of the write-back fields, at the bank address width.
  logic [ADDR_W-1:0] wa_s;
  logic              wr_store_s;

  assign wa_s       = bus.wa;
  // Writes to R15 are rejected here. Fetch handles the PC redirect.
  assign wr_store_s = bus.we && !is_pc(reg_addr_t'(wa_s));

  reg_read_port #(.WIDTH(WIDTH)) u_port1 (
    .regs_i  (regs_q),
    .ra_i    (reg_addr_t'(bus.ra1)),
    .pc8_i   (bus.pc8),
    .we_i    (bus.we),
    .wa_i    (reg_addr_t'(wa_s)),
    .wd_i    (bus.wd),
    .rdata_o (sel1_s)
  );

  reg_read_port #(.WIDTH(WIDTH)) u_port2 (
    .regs_i  (regs_q),
    .ra_i    (reg_addr_t'(bus.ra2)),
    .pc8_i   (bus.pc8),
    .we_i    (bus.we),
    .wa_i    (reg_addr_t'(wa_s)),
    .wd_i    (bus.wd),
    .rdata_o (sel2_s)
  );

  reg_read_port #(.WIDTH(WIDTH)) u_port3 (
    .regs_i  (regs_q),
    .ra_i    (reg_addr_t'(bus.ra3)),
    .pc8_i   (bus.pc8),
    .we_i    (bus.we),
    .wa_i    (reg_addr_t'(wa_s)),
    .wd_i    (bus.wd),
    .rdata_o (sel3_s)
  );

  // Register storage: clear on reset, otherwise a single write-back port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STORED_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_store_s) begin
      regs_q[wa_s] <= bus.wd;
    end
  end

  // Next-state for the read outputs (they hold while ren is low) and for the status pulses.
  always_comb begin
    rd1_d    = rd1_q;
    rd2_d    = rd2_q;
    rd3_d    = rd3_q;
    rvalid_d = 1'b0;
    pc_wr_d  = bus.we && is_pc(reg_addr_t'(wa_s));
    if (bus.ren) begin
      rd1_d    = sel1_s;
      rd2_d    = sel2_s;
      rd3_d    = sel3_s;
      rvalid_d = 1'b1;
    end else begin
      rvalid_d = 1'b0;
    end
  end

  // Output and status flops. An asynchronous reset clears them mid-cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd1_q    <= '0;
      rd2_q    <= '0;
      rd3_q    <= '0;
      rvalid_q <= 1'b0;
      pc_wr_q  <= 1'b0;
    end else begin
      rd1_q    <= rd1_d;
      rd2_q    <= rd2_d;
      rd3_q    <= rd3_d;
      rvalid_q <= rvalid_d;
      pc_wr_q  <= pc_wr_d;
    end
  end

  assign bus.rd1    = rd1_q;
  assign bus.rd2    = rd2_q;
  assign bus.rd3    = rd3_q;
  assign bus.rvalid = rvalid_q;
  assign bus.pc_wr  = pc_wr_q;

endmodule

// File: tb/tb_reg_file16.sv
// -----------------------------------------------------------------------------
// tb_reg_file16: scoreboard bench for reg_file16. The stimulus pushes the
// expected read triples and the expected pc_wr pulses. A negedge monitor pops
// and compares them whenever the DUT raises rvalid or pc_wr.
// -----------------------------------------------------------------------------
module tb_reg_file16;

  typedef struct {
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] e3;
  } exp_t;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  exp_t exp_q[$];
  int   pc_wr_pending;
  logic [31:0] hold1, hold2, hold3;

  reg_file16_if #(.WIDTH(32), .ADDR_W(4)) bus ();

  reg_file16 #(.WIDTH(32), .ADDR_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ren = 1'b0;
    bus.we  = 1'b0;
  endtask

  // Issue one read request for the coming edge and record its expectation.
  task automatic rd(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] a3,
                    input logic [31:0] x1, input logic [31:0] x2, input logic [31:0] x3);
    exp_t e;
    bus.ren = 1'b1;
    bus.ra1 = a1;
    bus.ra2 = a2;
    bus.ra3 = a3;
    e.e1 = x1;
    e.e2 = x2;
    e.e3 = x3;
    exp_q.push_back(e);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus.we = 1'b1;
    bus.wa = a;
    bus.wd = d;
    if (a == 4'd15) pc_wr_pending++;
  endtask

  // Monitor: compare every rvalid/pc_wr presentation against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.rvalid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_rvalid", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("rd1", bus.rd1, e.e1);
            chk("rd2", bus.rd2, e.e2);
            chk("rd3", bus.rd3, e.e3);
          end
        end
        if (bus.pc_wr) begin
          chk("pc_wr_expected", 32'(pc_wr_pending > 0), 32'd1);
          if (pc_wr_pending > 0) pc_wr_pending--;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    errors = 0;
    checks = 0;
    pc_wr_pending = 0;
    reset  = 1'b1;
    bus.ren = 1'b0; bus.we = 1'b0;
    bus.ra1 = 4'd0; bus.ra2 = 4'd0; bus.ra3 = 4'd0;
    bus.wa  = 4'd0; bus.wd = 32'd0; bus.pc8 = 32'd0;
    tick(); tick();
    chk("reset_rd1", bus.rd1, 32'd0);
    chk("reset_rvalid", 32'(bus.rvalid), 32'd0);
    chk("reset_pc_wr", 32'(bus.pc_wr), 32'd0);
    reset = 1'b0;

    // Reset asserted mid-cycle while a read is in flight.
    wr(4'd1, 32'h0000_0005);
    tick();
    idle();
    rd(4'd1, 4'd1, 4'd1, 32'd5, 32'd5, 32'd5);
    tick();
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    chk("midreset_rd1", bus.rd1, 32'd0);
    chk("midreset_rd2", bus.rd2, 32'd0);
    chk("midreset_rd3", bus.rd3, 32'd0);
    chk("midreset_rvalid", 32'(bus.rvalid), 32'd0);
    tick();
    reset = 1'b0;
    idle();
    rd(4'd1, 4'd0, 4'd1, 32'd0, 32'd0, 32'd0);
    tick();

    // Write R3, then read it one cycle later.
    idle();
    wr(4'd3, 32'h0000_00A5);
    tick();
    idle();
    rd(4'd3, 4'd0, 4'd0, 32'h0000_00A5, 32'd0, 32'd0);
    tick();
    idle();

    // R15 reads return pc8.
    bus.pc8 = 32'h0000_0108;
    rd(4'd3, 4'd15, 4'd15, 32'h0000_00A5, 32'h0000_0108, 32'h0000_0108);
    tick();
    idle();

    // A write to R15 is rejected, and pc_wr pulses for exactly one cycle.
    wr(4'd15, 32'hDEAD_BEEF);
    tick();
    idle();
    #1;
    chk("pc_wr_pulse", 32'(bus.pc_wr), 32'd1);
    tick();
    chk("pc_wr_single", 32'(bus.pc_wr), 32'd0);
    bus.pc8 = 32'h0000_0200;
    rd(4'd15, 4'd15, 4'd3, 32'h0000_0200, 32'h0000_0200, 32'h0000_00A5);
    tick();
    idle();

    // Same-edge read and write of R7.
    wr(4'd7, 32'h1111_1111);
    tick();
    idle();
    wr(4'd7, 32'h2222_2222);
`ifdef REGFILE_BYPASS_EN
    rd(4'd7, 4'd3, 4'd7, 32'h2222_2222, 32'h0000_00A5, 32'h2222_2222);
`else
    rd(4'd7, 4'd3, 4'd7, 32'h1111_1111, 32'h0000_00A5, 32'h1111_1111);
`endif
    tick();
    idle();
    rd(4'd7, 4'd7, 4'd7, 32'h2222_2222, 32'h2222_2222, 32'h2222_2222);
    tick();
    idle();

    // Fill R0-R14 with i<<4.
    for (int i = 0; i < 15; i++) begin
      wr(4'(i), 32'(i) << 4);
      tick();
    end
    idle();

    // Back-to-back reads keep rvalid high continuously.
    rd(4'd1, 4'd2, 4'd3, 32'h10, 32'h20, 32'h30);
    tick();
    chk("b2b_rvalid_1", 32'(bus.rvalid), 32'd1);
    rd(4'd4, 4'd5, 4'd6, 32'h40, 32'h50, 32'h60);
    tick();
    chk("b2b_rvalid_2", 32'(bus.rvalid), 32'd1);
    rd(4'd0, 4'd14, 4'd14, 32'h00, 32'hE0, 32'hE0);
    tick();
    idle();
    hold1 = 32'h00; hold2 = 32'hE0; hold3 = 32'hE0;

    // With ren dropped for 3 cycles the outputs hold and rvalid stays low.
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("hold_rvalid", 32'(bus.rvalid), 32'd0);
      chk("hold_rd1", bus.rd1, hold1);
      chk("hold_rd2", bus.rd2, hold2);
      chk("hold_rd3", bus.rd3, hold3);
    end

    tick(); tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("pc_wr_drained", 32'(pc_wr_pending), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
